// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, enables, memory handshake and a sticky fault.
// Ports: clk, rst (sync, active-high); instr and ALU flags zero/carry/sign/
// overflow; mem_ready in; mem_req, adr_src, mem_write, ir_write, pc_write,
// reg_write, alu_src_a/b, result_src, alu_op, fault, state (debug) out.
module multicycle_controller #(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit CARRY_IS_BORROW = 1'b0,
  parameter int WAIT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        carry,
  input  logic        sign,
  input  logic        overflow,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_op,
  output logic        fault,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_BRANCH   = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  localparam int TMO_LAST =
    (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] LAST =
    WAIT_W'(TMO_LAST);
  localparam logic [WAIT_W-1:0] SAT =
    {WAIT_W{1'b1}};

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  logic lt, ltu, taken, br_bad;
  logic in_wait, timeout;

  assign lt  = sign ^ overflow;
  assign ltu = carry ^ ~CARRY_IS_BORROW;
  assign br_bad = (funct3 == 3'b010) ||
                  (funct3 == 3'b011);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  assign in_wait = (state_q == S_FETCH) ||
                   (state_q == S_MEMREAD) ||
                   (state_q == S_MEMWRITE);

  // A completing transfer on the last allowed cycle beats the timeout.
  assign timeout = (MEM_TIMEOUT != 0) && in_wait &&
                   !mem_ready && (wait_q == LAST);

  // Transitions between wait states only occur on mem_ready, so clearing
  // on ready or outside wait states also clears on every entry.
  always_comb begin
    wait_d = '0;
    if (in_wait && !mem_ready && wait_q != SAT)
      wait_d = wait_q + WAIT_W'(1);
    else if (in_wait && !mem_ready)
      wait_d = wait_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0000011: state_d = S_MEMADR;
          7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXEC_R;
          7'b0010011: state_d = S_EXEC_I;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b1100111:
            state_d = (funct3 == 3'b000) ?
                      S_JALR : S_FAULT;
          7'b0110111: state_d = S_LUI;
          7'b0010111: state_d = S_ALUWB;
          default:    state_d = S_FAULT;
        endcase
      end
      S_MEMADR:
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE:
        if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:
        state_d = br_bad ? S_FAULT : S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
    if (timeout) state_d = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are decoded from the state plus same-cycle inputs so that
  // the fetch handshake, branch decision and reset take effect at once.
  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_op     = 2'b00;
    fault      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        S_LUI: begin
          alu_src_b = 2'b01;
          alu_op    = 2'b11;
        end
        S_ALUWB: reg_write = 1'b1;
        S_JALR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = taken;
        end
        S_FAULT: fault = 1'b1;
        default: fault = 1'b1;
      endcase
    end
  end

  assign state = rst ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// random instruction streams checked against a phase-level reference model.
module tb_multicycle_controller;

  localparam int TMO = 4;
  localparam bit CIB = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        carry = 1'b0;
  logic        sign = 1'b0;
  logic        overflow = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, adr_src, mem_write;
  logic        ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b;
  logic [1:0]  result_src, alu_op;
  logic        fault;
  logic [3:0]  state;

  always #5 clk = ~clk;

  multicycle_controller #(
    .MEM_TIMEOUT(TMO),
    .CARRY_IS_BORROW(CIB),
    .WAIT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .zero(zero), .carry(carry), .sign(sign),
    .overflow(overflow), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op),
    .fault(fault), .state(state)
  );

  typedef struct packed {
    logic       mreq, asrc, mwr, irw, pcw, rgw;
    logic [1:0] a, b, rs, op;
    logic       flt;
  } ctl_t;

  typedef enum {
    P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD,
    P_MEMWB, P_MEMWRITE, P_EXEC_R, P_EXEC_I, P_LUI,
    P_ALUWB, P_JALR, P_JAL, P_BRANCH, P_FAULT
  } ph_t;

  ctl_t obs;
  assign obs = {mem_req, adr_src, mem_write, ir_write,
                pc_write, reg_write, alu_src_a, alu_src_b,
                result_src, alu_op, fault};

  int n_chk = 0;
  int n_pass = 0;

  function automatic logic br_taken(
    input logic [2:0] f3, input logic [31:0] r1,
    input logic [31:0] r2);
    case (f3)
      3'd0: return r1 == r2;
      3'd1: return r1 != r2;
      3'd4: return $signed(r1) < $signed(r2);
      3'd5: return $signed(r1) >= $signed(r2);
      3'd6: return r1 < r2;
      3'd7: return r1 >= r2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctl_t model(
    input ph_t p, input logic rdy, input logic [2:0] f3,
    input logic [31:0] r1, input logic [31:0] r2);
    ctl_t c = '0;
    case (p)
      P_FETCH: begin
        c.mreq = 1; c.b = 2; c.rs = 2;
        c.irw = rdy; c.pcw = rdy;
      end
      P_DECODE:   begin c.a = 1; c.b = 1; end
      P_MEMADR:   begin c.a = 2; c.b = 1; end
      P_MEMREAD:  begin c.mreq = 1; c.asrc = 1; end
      P_MEMWB:    begin c.rs = 1; c.rgw = 1; end
      P_MEMWRITE: begin
        c.mreq = 1; c.mwr = 1; c.asrc = 1;
      end
      P_EXEC_R:   begin c.a = 2; c.op = 2; end
      P_EXEC_I:   begin c.a = 2; c.b = 1; c.op = 2; end
      P_LUI:      begin c.b = 1; c.op = 3; end
      P_ALUWB:    c.rgw = 1;
      P_JALR:     begin c.a = 2; c.b = 1; end
      P_JAL:      begin c.a = 1; c.b = 2; c.pcw = 1; end
      P_BRANCH: begin
        c.a = 2; c.op = 1;
        c.pcw = br_taken(f3, r1, r2);
      end
      P_FAULT:    c.flt = 1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input ctl_t exp, input string tag);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  // ALU flags as produced by rs1 - rs2 in a real datapath.
  task automatic drive_flags(input logic [31:0] r1,
                             input logic [31:0] r2);
    logic [32:0] d;
    d = {1'b0, r1} - {1'b0, r2};
    zero     = (d[31:0] == 32'd0);
    sign     = d[31];
    overflow = (r1[31] ^ r2[31]) & (d[31] ^ r1[31]);
    carry    = CIB ? d[32] : ~d[32];
  endtask

  task automatic cyc(input ph_t p, input logic rdy,
                     input logic [31:0] ins,
                     input logic [31:0] r1,
                     input logic [31:0] r2,
                     input string tag);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = rdy;
    instr = ins;
    drive_flags(r1, r2);
    #1;
    check(model(p, rdy, ins[14:12], r1, r2), tag);
  endtask

  task automatic do_reset(input logic rdy,
                          input string tag);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = rdy;
    #1;
    check('0, tag);
  endtask

  task automatic run_instr(input logic [31:0] ins,
                           input int wf, input int wm,
                           input logic [31:0] r1,
                           input logic [31:0] r2,
                           input string tag);
    ph_t seq[$];
    logic [2:0] f3;
    bit flt;
    f3 = ins[14:12];
    flt = 0;
    repeat (wf) cyc(P_FETCH, 0, ins, r1, r2, tag);
    cyc(P_FETCH, 1, ins, r1, r2, tag);
    cyc(P_DECODE, 1'($urandom), ins, r1, r2, tag);
    case (ins[6:0])
      7'b0000011: seq = '{P_MEMADR, P_MEMREAD, P_MEMWB};
      7'b0100011: seq = '{P_MEMADR, P_MEMWRITE};
      7'b0110011: seq = '{P_EXEC_R, P_ALUWB};
      7'b0010011: seq = '{P_EXEC_I, P_ALUWB};
      7'b1100011: begin
        seq = '{P_BRANCH};
        flt = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'b1101111: seq = '{P_JAL, P_ALUWB};
      7'b1100111:
        if (f3 == 3'd0) seq = '{P_JALR, P_JAL, P_ALUWB};
        else flt = 1;
      7'b0110111: seq = '{P_LUI, P_ALUWB};
      7'b0010111: seq = '{P_ALUWB};
      default: flt = 1;
    endcase
    foreach (seq[i]) begin
      if (seq[i] == P_MEMREAD || seq[i] == P_MEMWRITE) begin
        repeat (wm) cyc(seq[i], 0, ins, r1, r2, tag);
        cyc(seq[i], 1, ins, r1, r2, tag);
      end else begin
        cyc(seq[i], 1'($urandom), ins, r1, r2, tag);
      end
    end
    if (flt) begin
      cyc(P_FAULT, 1'($urandom), ins, r1, r2, tag);
      cyc(P_FAULT, 1, ins, r1, r2, tag);
      do_reset(1'($urandom), "fault_rst");
    end
  endtask

  logic [6:0] ops [10] = '{
    7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
    7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
    7'b0010111, 7'b1111111
  };

  initial begin
    logic [31:0] ins, r1, r2;

    do_reset(1, "reset_state");

    run_instr(32'h00500093, 0, 0, 1, 2, "addi");
    run_instr(32'h00002103, 0, 3, 3, 4, "lw_wait3");
    run_instr(32'h00000063, 0, 0, 7, 7, "beq_z1");
    run_instr(32'h00000063, 0, 0, 7, 8, "beq_z0");
    run_instr(32'h00006063, 0, 0, 5, 9, "bltu_c0");
    run_instr(32'h00006063, 0, 0, 9, 5, "bltu_c1");
    run_instr(32'h0000C063, 0, 0, 32'hFFFF_FFFF, 1,
              "blt_neg");
    run_instr(32'h008100E7, 0, 0, 1, 1, "jalr");
    run_instr(32'h00002023, 3, 3, 1, 1, "sw_wait");
    run_instr(32'h00000000, 0, 0, 1, 1, "illegal_op");
    run_instr(32'h00002063, 0, 0, 1, 1, "br_f3_010");
    run_instr(32'h000010E7, 0, 0, 1, 1, "jalr_f3");

    // Fetch timeout: four waiting cycles, then sticky fault.
    repeat (TMO) cyc(P_FETCH, 0, 0, 1, 1, "tmo_fetch");
    cyc(P_FAULT, 0, 0, 1, 1, "tmo_fault");
    cyc(P_FAULT, 1, 0, 1, 1, "tmo_sticky");
    cyc(P_FAULT, 1, 0, 1, 1, "tmo_sticky");
    do_reset(0, "tmo_rst");
    run_instr(32'h00500093, 0, 0, 1, 2, "post_tmo");

    // Memory-read timeout.
    ins = 32'h00002103;
    cyc(P_FETCH, 1, ins, 1, 1, "rd_tmo");
    cyc(P_DECODE, 1, ins, 1, 1, "rd_tmo");
    cyc(P_MEMADR, 1, ins, 1, 1, "rd_tmo");
    repeat (TMO) cyc(P_MEMREAD, 0, ins, 1, 1, "rd_tmo");
    cyc(P_FAULT, 1, ins, 1, 1, "rd_tmo_fault");
    do_reset(0, "rd_tmo_rst");

    // Reset in the middle of a store.
    ins = 32'h00002023;
    cyc(P_FETCH, 1, ins, 1, 1, "sw_rst");
    cyc(P_DECODE, 1, ins, 1, 1, "sw_rst");
    cyc(P_MEMADR, 1, ins, 1, 1, "sw_rst");
    cyc(P_MEMWRITE, 0, ins, 1, 1, "sw_rst");
    do_reset(1, "sw_rst_drop");
    run_instr(32'h00500093, 0, 0, 1, 2, "post_sw_rst");

    for (int k = 0; k < 60; k++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      run_instr(ins, $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1), r1, r2,
                "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
